// File: rtl/sc_jug_move_pkg.sv
// Shared state encoding and shift-command constants for the player movement controller.
package sc_jug_move_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        L_FIRST  = 3'd1,
        L_REPEAT = 3'd2,
        R_FIRST  = 3'd3,
        R_REPEAT = 3'd4,
        BLOCKED  = 3'd5
    } move_state_e;

    localparam logic [1:0] SHIFT_NONE  = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

endpackage

// File: rtl/sc_jug_debounce.sv
// Two-flop synchronizer plus debouncer for one raw active-low push-button.
module sc_jug_debounce
    import sc_jug_move_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH       = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed
);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 acc_q, acc_d;
    logic                 pressed_q, pressed_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d   = btn_n;
        sync2_d   = sync1_q;
        acc_d     = acc_q;
        cnt_d     = '0;
        // Extra stage between accepted level and FSM sets the press-to-pulse latency.
        pressed_d = ~acc_q;
        if (sync2_q != acc_q) begin
            if (cnt_q == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
                acc_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            acc_q     <= 1'b1;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
        end
    end

    assign pressed = pressed_q;

endmodule

// File: rtl/sc_jug_move_ctrl.sv
// Hold/auto-repeat movement controller issuing one-cycle shift commands to the position register.
module sc_jug_move_ctrl
    import sc_jug_move_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 12500000,
    parameter int unsigned CNT_WIDTH       = 25
) (
    input  logic       SC_JUGMOVE_CLOCK_50,
    input  logic       SC_JUGMOVE_RESET_InHigh,
    input  logic       SC_JUGMOVE_left_InLow,
    input  logic       SC_JUGMOVE_right_InLow,
    input  logic       SC_JUGMOVE_enable_InHigh,
    output logic [1:0] SC_JUGMOVE_shiftselection_OutBUS
);

    localparam logic [CNT_WIDTH-1:0] DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

    logic                 pl, pr;
    move_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] rep_q, rep_d;
    logic [1:0]           shift_q, shift_d;
    logic [CNT_WIDTH-1:0] rep_last;

    sc_jug_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_deb_left (
        .clk     (SC_JUGMOVE_CLOCK_50),
        .rst     (SC_JUGMOVE_RESET_InHigh),
        .btn_n   (SC_JUGMOVE_left_InLow),
        .pressed (pl)
    );

    sc_jug_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_deb_right (
        .clk     (SC_JUGMOVE_CLOCK_50),
        .rst     (SC_JUGMOVE_RESET_InHigh),
        .btn_n   (SC_JUGMOVE_right_InLow),
        .pressed (pr)
    );

    always_comb begin
        state_d  = state_q;
        rep_d    = '0;
        shift_d  = SHIFT_NONE;
        rep_last = (state_q == L_FIRST || state_q == R_FIRST) ? DELAY_LAST : PERIOD_LAST;
        if (!SC_JUGMOVE_enable_InHigh) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pl && !pr) begin
                        state_d = L_FIRST;
                        shift_d = SHIFT_LEFT;
                    end else if (pr && !pl) begin
                        state_d = R_FIRST;
                        shift_d = SHIFT_RIGHT;
                    end else if (pl && pr) begin
                        state_d = BLOCKED;
                    end
                end
                L_FIRST, L_REPEAT: begin
                    if (!pl) begin
                        state_d = IDLE;
                    end else if (pr) begin
                        state_d = BLOCKED;
                    end else if (rep_q == rep_last) begin
                        state_d = L_REPEAT;
                        shift_d = SHIFT_LEFT;
                    end else begin
                        rep_d = rep_q + CNT_WIDTH'(1);
                    end
                end
                R_FIRST, R_REPEAT: begin
                    if (!pr) begin
                        state_d = IDLE;
                    end else if (pl) begin
                        state_d = BLOCKED;
                    end else if (rep_q == rep_last) begin
                        state_d = R_REPEAT;
                        shift_d = SHIFT_RIGHT;
                    end else begin
                        rep_d = rep_q + CNT_WIDTH'(1);
                    end
                end
                BLOCKED: begin
                    if (!pl && !pr) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge SC_JUGMOVE_CLOCK_50) begin
        if (SC_JUGMOVE_RESET_InHigh) begin
            state_q <= IDLE;
            rep_q   <= '0;
            shift_q <= SHIFT_NONE;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            shift_q <= shift_d;
        end
    end

    assign SC_JUGMOVE_shiftselection_OutBUS = shift_q;

endmodule

// File: tb/tb_sc_jug_move_ctrl.sv
// Directed and randomized checks of sc_jug_move_ctrl against a cycle-level behavioural model.
module tb_sc_jug_move_ctrl;
    import sc_jug_move_pkg::*;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 5;

    logic       clk;
    logic       rst;
    logic       left_n;
    logic       right_n;
    logic       en;
    logic [1:0] shift;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int got_l[$];
    int got_r[$];

    // Model: per button index 0=left 1=right; levels are raw (1 = released).
    int m_sync1[2];
    int m_sync2[2];
    int m_acc[2];
    int m_run[2];
    int m_seen[2];
    int m_mode;   // 0 idle, 1 moving left, 2 moving right, 3 blocked
    int m_since;
    int m_first;
    int m_out;

    sc_jug_move_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_WIDTH      (25)
    ) dut (
        .SC_JUGMOVE_CLOCK_50             (clk),
        .SC_JUGMOVE_RESET_InHigh         (rst),
        .SC_JUGMOVE_left_InLow           (left_n),
        .SC_JUGMOVE_right_InLow          (right_n),
        .SC_JUGMOVE_enable_InHigh        (en),
        .SC_JUGMOVE_shiftselection_OutBUS(shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input int l_raw, input int r_raw, input int e, input int rs);
        int raw[2];
        int own, other;
        raw[0] = l_raw;
        raw[1] = r_raw;
        if (rs != 0) begin
            for (int b = 0; b < 2; b++) begin
                m_sync1[b] = 1; m_sync2[b] = 1; m_acc[b] = 1; m_run[b] = 0; m_seen[b] = 0;
            end
            m_mode = 0; m_since = 0; m_first = 0; m_out = 0;
            return;
        end
        m_out = 0;
        if (e == 0) begin
            m_mode  = 0;
            m_since = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (m_seen[0] != 0 && m_seen[1] == 0) begin
                        m_mode = 1; m_out = 1; m_since = 0; m_first = 1;
                    end else if (m_seen[1] != 0 && m_seen[0] == 0) begin
                        m_mode = 2; m_out = 2; m_since = 0; m_first = 1;
                    end else if (m_seen[0] != 0 && m_seen[1] != 0) begin
                        m_mode = 3;
                    end
                end
                1, 2: begin
                    own   = m_seen[m_mode - 1];
                    other = m_seen[2 - m_mode];
                    if (own == 0) begin
                        m_mode = 0; m_since = 0;
                    end else if (other != 0) begin
                        m_mode = 3; m_since = 0;
                    end else begin
                        m_since++;
                        if (m_since == ((m_first != 0) ? int'(RD) : int'(RP))) begin
                            m_out = m_mode; m_since = 0; m_first = 0;
                        end
                    end
                end
                default: begin
                    if (m_seen[0] == 0 && m_seen[1] == 0) m_mode = 0;
                end
            endcase
        end
        for (int b = 0; b < 2; b++) begin
            m_seen[b] = (m_acc[b] == 0) ? 1 : 0;
            // Accept a new level after DB consecutive differing synchronized samples.
            if (m_sync2[b] != m_acc[b]) begin
                m_run[b]++;
                if (m_run[b] == int'(DB)) begin
                    m_acc[b] = m_sync2[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
            m_sync2[b] = m_sync1[b];
            m_sync1[b] = raw[b];
        end
    endtask

    task automatic tick(input logic l_n, input logic r_n, input logic e, input logic rs);
        left_n  = l_n;
        right_n = r_n;
        en      = e;
        rst     = rs;
        model_step(int'(l_n), int'(r_n), int'(e), int'(rs));
        @(posedge clk);
        @(negedge clk);
        tests++;
        assert (shift === 2'(m_out)) else begin
            fails++;
            $error("FAIL shift cyc=%0d observed=%b expected=%b", cyc, shift, 2'(m_out));
        end
        if (shift === SHIFT_LEFT)  got_l.push_back(cyc);
        if (shift === SHIFT_RIGHT) got_r.push_back(cyc);
        cyc++;
    endtask

    task automatic run(input int n, input logic l_n, input logic r_n, input logic e);
        for (int i = 0; i < n; i++) tick(l_n, r_n, e, 1'b0);
    endtask

    task automatic start_scn();
        cyc = 0;
        got_l.delete();
        got_r.delete();
    endtask

    function automatic string q2s(input int q[$]);
        string s = "{";
        foreach (q[i]) s = {s, $sformatf(" %0d", q[i])};
        return {s, " }"};
    endfunction

    task automatic check_list(input string tag, input int got[$], input int exp[$]);
        int ok;
        ok = (got.size() == exp.size()) ? 1 : 0;
        if (ok != 0) foreach (exp[i]) if (got[i] != exp[i]) ok = 0;
        tests++;
        assert (ok == 1) else begin
            fails++;
            $error("FAIL %s observed=%s expected=%s", tag, q2s(got), q2s(exp));
        end
    endtask

    initial begin
        int none[$];
        int seg_len;
        logic rl, rr, re;
        none.delete();
        left_n = 1'b1; right_n = 1'b1; en = 1'b1; rst = 1'b1;

        // Reset and idle
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tests++;
        assert (dut.state_q === IDLE) else begin
            fails++; $error("FAIL reset_state observed=%0d expected=%0d", dut.state_q, IDLE);
        end
        start_scn();
        run(50, 1'b1, 1'b1, 1'b1);
        check_list("idle_left", got_l, none);
        check_list("idle_right", got_r, none);

        // Left held with auto-repeat
        start_scn();
        run(35, 1'b0, 1'b1, 1'b1);
        run(15, 1'b1, 1'b1, 1'b1);
        check_list("hold_left", got_l, '{7, 17, 22, 27, 32, 37});
        check_list("hold_left_no_right", got_r, none);

        // Right bounce shorter than the window, then a short real press
        start_scn();
        run(3, 1'b1, 1'b0, 1'b1);
        run(12, 1'b1, 1'b1, 1'b1);
        check_list("bounce_right", got_r, none);
        start_scn();
        run(6, 1'b1, 1'b0, 1'b1);
        run(20, 1'b1, 1'b1, 1'b1);
        check_list("short_right", got_r, '{7});

        // Left held, right joins: blocked
        start_scn();
        run(10, 1'b0, 1'b1, 1'b1);
        run(20, 1'b0, 1'b0, 1'b1);
        run(15, 1'b1, 1'b1, 1'b1);
        check_list("blocked_left", got_l, '{7});
        check_list("blocked_right", got_r, none);
        start_scn();
        run(9, 1'b0, 1'b1, 1'b1);
        run(12, 1'b1, 1'b1, 1'b1);
        check_list("after_block_left", got_l, '{7});

        // Both pressed together
        start_scn();
        run(20, 1'b0, 1'b0, 1'b1);
        run(15, 1'b1, 1'b1, 1'b1);
        check_list("both_left", got_l, none);
        check_list("both_right", got_r, none);

        // Enable drop while held
        start_scn();
        run(9, 1'b0, 1'b1, 1'b1);
        run(11, 1'b0, 1'b1, 1'b0);
        run(13, 1'b0, 1'b1, 1'b1);
        run(12, 1'b1, 1'b1, 1'b1);
        check_list("enable_left", got_l, '{7, 20, 30, 35});

        // Reset mid-hold
        start_scn();
        run(15, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        tests++;
        assert (dut.state_q === IDLE) else begin
            fails++; $error("FAIL midreset_state observed=%0d expected=%0d", dut.state_q, IDLE);
        end
        run(14, 1'b0, 1'b1, 1'b1);
        run(15, 1'b1, 1'b1, 1'b1);
        check_list("reset_left", got_l, '{7, 23, 33});

        // Randomized segments against the model
        for (int s = 0; s < 60; s++) begin
            seg_len = int'($urandom_range(1, 24));
            rl = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            rr = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
            re = ($urandom_range(0, 5) != 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                rl = 1'b1; rr = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) tick(rl, rr, re, 1'b1);
            run(seg_len, rl, rr, re);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
